// File: rtl/fragment_shader_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the fragment shading stage.
package raster_pkg;

   localparam logic [31:0] FP_ONE      = 32'h0001_0000;
   localparam int          FP_FRAC     = 16;
   localparam int          SCREEN_W    = 640;
   localparam int          PIXEL_BYTES = 8;
   localparam int          DEPTH_OFS   = 4;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SHADE      = 3'd1,
      S_RD_DEPTH   = 3'd2,
      S_WAIT_DEPTH = 3'd3,
      S_WR_COLOR   = 3'd4,
      S_WR_DEPTH   = 3'd5
   } fs_state_t;

   // Saturate a signed integer channel value into the 0..255 range.
   function automatic logic [7:0] clamp_u8(input logic signed [41:0] v);
      logic [7:0] r;
      if (v < 42'sd0) begin
         r = 8'h00;
      end else if (v > 42'sd255) begin
         r = 8'hFF;
      end else begin
         r = v[7:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/fragment_shader_if.sv
// Fragment input handshake plus Avalon-MM framebuffer master, bundled as one interface.
interface fragment_shader_if #(
   parameter int ADDR_W = 26
);
   logic [ADDR_W-1:0] addr_in;
   logic [23:0]       color_in_1;
   logic [23:0]       color_in_2;
   logic [23:0]       color_in_3;
   logic [31:0]       w1_in;
   logic [31:0]       w2_in;
   logic [31:0]       depth_in;
   logic              in_valid;
   logic              stall_out;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_writedata;
   logic [31:0]       mem_readdata;
   logic              mem_readdatavalid;
   logic              mem_waitrequest;

   modport master (
      input  addr_in, color_in_1, color_in_2, color_in_3, w1_in, w2_in, depth_in, in_valid,
      input  mem_readdata, mem_readdatavalid, mem_waitrequest,
      output stall_out, mem_addr, mem_read, mem_write, mem_writedata
   );

   modport slave (
      output addr_in, color_in_1, color_in_2, color_in_3, w1_in, w2_in, depth_in, in_valid,
      output mem_readdata, mem_readdatavalid, mem_waitrequest,
      input  stall_out, mem_addr, mem_read, mem_write, mem_writedata
   );
endinterface

// File: rtl/fragment_shader_color_interp.sv
// One colour channel: barycentric weighted sum of three vertex values, floored to integer and saturated.
module color_interp
   import raster_pkg::*;
(
   input  logic signed [31:0] w1,
   input  logic signed [31:0] w2,
   input  logic signed [31:0] w3,
   input  logic [7:0]         c1,
   input  logic [7:0]         c2,
   input  logic [7:0]         c3,
   output logic [7:0]         ch
);
   logic signed [41:0] p1, p2, p3, sum;

   // Channels enter as non-negative 9-bit signed so the products keep the weight's sign.
   always_comb begin
      p1  = 42'(w1) * 42'(signed'({1'b0, c1}));
      p2  = 42'(w2) * 42'(signed'({1'b0, c2}));
      p3  = 42'(w3) * 42'(signed'({1'b0, c3}));
      sum = p1 + p2 + p3;
      ch  = clamp_u8(sum >>> FP_FRAC);
   end
endmodule

// File: rtl/fragment_shader.sv
// Per-fragment colour interpolation, depth test and framebuffer write-back over Avalon-MM.
module fragment_shader
   import raster_pkg::*;
#(
   parameter bit DEPTH_TEST_EN  = 1'b1,
   parameter bit DEPTH_WRITE_EN = 1'b1,
   parameter int ADDR_W         = 26
) (
   input  logic              clock,
   input  logic              reset,
   fragment_shader_if.master bus,
   input  logic              done_in,
   output logic              done_out,
   output logic [31:0]       frag_in_count,
   output logic [31:0]       frag_drawn_count
);
   fs_state_t         state_r, next_state_s;
   logic [ADDR_W-1:0] addr_r, mem_addr_r, addr_nx_s;
   logic [23:0]       c1_r, c2_r, c3_r, rgb_r, rgb_s, color_s;
   logic [31:0]       w1_r, w2_r, depth_r, w3_s;
   logic [31:0]       mem_wdata_r, wdata_nx_s, in_cnt_r, drawn_cnt_r;
   logic              stall_r, mem_read_r, mem_write_r, done_r;
   logic              accept_s, drawn_inc_s, rd_nx_s, wr_nx_s;

   assign accept_s = (state_r == S_IDLE) && bus.in_valid;
   assign w3_s     = FP_ONE - w1_r - w2_r;

   color_interp u_red   (.w1(w1_r), .w2(w2_r), .w3(w3_s), .c1(c1_r[23:16]), .c2(c2_r[23:16]),
                         .c3(c3_r[23:16]), .ch(rgb_s[23:16]));
   color_interp u_green (.w1(w1_r), .w2(w2_r), .w3(w3_s), .c1(c1_r[15:8]), .c2(c2_r[15:8]),
                         .c3(c3_r[15:8]), .ch(rgb_s[15:8]));
   color_interp u_blue  (.w1(w1_r), .w2(w2_r), .w3(w3_s), .c1(c1_r[7:0]), .c2(c2_r[7:0]),
                         .c3(c3_r[7:0]), .ch(rgb_s[7:0]));

   // Next-state decode; a fragment counts as drawn when its last write is accepted.
   always_comb begin
      next_state_s = state_r;
      drawn_inc_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (accept_s) next_state_s = S_SHADE;
            else          next_state_s = S_IDLE;
         end
         S_SHADE: begin
            if (DEPTH_TEST_EN) next_state_s = S_RD_DEPTH;
            else               next_state_s = S_WR_COLOR;
         end
         S_RD_DEPTH: begin
            if (!bus.mem_waitrequest) next_state_s = S_WAIT_DEPTH;
            else                      next_state_s = S_RD_DEPTH;
         end
         S_WAIT_DEPTH: begin
            if (!bus.mem_readdatavalid)                           next_state_s = S_WAIT_DEPTH;
            else if ($signed(depth_r) < $signed(bus.mem_readdata)) next_state_s = S_WR_COLOR;
            else                                                   next_state_s = S_IDLE;
         end
         S_WR_COLOR: begin
            if (bus.mem_waitrequest) begin
               next_state_s = S_WR_COLOR;
            end else if (DEPTH_WRITE_EN) begin
               next_state_s = S_WR_DEPTH;
            end else begin
               next_state_s = S_IDLE;
               drawn_inc_s  = 1'b1;
            end
         end
         S_WR_DEPTH: begin
            if (bus.mem_waitrequest) begin
               next_state_s = S_WR_DEPTH;
            end else begin
               next_state_s = S_IDLE;
               drawn_inc_s  = 1'b1;
            end
         end
         default: next_state_s = S_IDLE;
      endcase
   end

   // Bus outputs are registered from the next state, so a held request stays bit-stable.
   always_comb begin
      rd_nx_s    = 1'b0;
      wr_nx_s    = 1'b0;
      addr_nx_s  = mem_addr_r;
      wdata_nx_s = mem_wdata_r;
      color_s    = (state_r == S_SHADE) ? rgb_s : rgb_r;
      case (next_state_s)
         S_RD_DEPTH: begin
            rd_nx_s   = 1'b1;
            addr_nx_s = addr_r + ADDR_W'(DEPTH_OFS);
         end
         S_WR_COLOR: begin
            wr_nx_s    = 1'b1;
            addr_nx_s  = addr_r;
            wdata_nx_s = {8'h00, color_s};
         end
         S_WR_DEPTH: begin
            wr_nx_s    = 1'b1;
            addr_nx_s  = addr_r + ADDR_W'(DEPTH_OFS);
            wdata_nx_s = depth_r;
         end
         default: rd_nx_s = 1'b0;
      endcase
   end

   // Fragment latch on accept and shaded colour capture.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_r  <= '0;
         c1_r    <= 24'h0;
         c2_r    <= 24'h0;
         c3_r    <= 24'h0;
         w1_r    <= 32'h0;
         w2_r    <= 32'h0;
         depth_r <= 32'h0;
         rgb_r   <= 24'h0;
      end else begin
         if (accept_s) begin
            addr_r  <= bus.addr_in;
            c1_r    <= bus.color_in_1;
            c2_r    <= bus.color_in_2;
            c3_r    <= bus.color_in_3;
            w1_r    <= bus.w1_in;
            w2_r    <= bus.w2_in;
            depth_r <= bus.depth_in;
         end
         if (state_r == S_SHADE) rgb_r <= rgb_s;
      end
   end

   // Control state, registered outputs and counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r     <= S_IDLE;
         stall_r     <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'h0;
         done_r      <= 1'b0;
         in_cnt_r    <= 32'h0;
         drawn_cnt_r <= 32'h0;
      end else begin
         state_r     <= next_state_s;
         stall_r     <= (next_state_s != S_IDLE);
         mem_read_r  <= rd_nx_s;
         mem_write_r <= wr_nx_s;
         mem_addr_r  <= addr_nx_s;
         mem_wdata_r <= wdata_nx_s;
         done_r      <= done_in && (state_r == S_IDLE) && !bus.in_valid;
         if (accept_s)    in_cnt_r    <= in_cnt_r + 32'd1;
         if (drawn_inc_s) drawn_cnt_r <= drawn_cnt_r + 32'd1;
      end
   end

   assign bus.stall_out     = stall_r;
   assign bus.mem_read      = mem_read_r;
   assign bus.mem_write     = mem_write_r;
   assign bus.mem_addr      = mem_addr_r;
   assign bus.mem_writedata = mem_wdata_r;
   assign done_out          = done_r;
   assign frag_in_count     = in_cnt_r;
   assign frag_drawn_count  = drawn_cnt_r;
endmodule

// File: tb/tb_fragment_shader.sv
// Directed bench for fragment_shader: arithmetic model, access scoreboard and Avalon slave responder.
module tb_fragment_shader;
   localparam int AW = 26;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        done_in;
   logic        done_out;
   logic [31:0] frag_in_count, frag_drawn_count;

   fragment_shader_if #(.ADDR_W(AW)) bus ();

   fragment_shader #(.DEPTH_TEST_EN(1'b1), .DEPTH_WRITE_EN(1'b1), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset), .bus(bus), .done_in(done_in), .done_out(done_out),
      .frag_in_count(frag_in_count), .frag_drawn_count(frag_drawn_count)
   );

   always #5 clock = ~clock;

   typedef struct { int kind; logic [AW-1:0] addr; logic [31:0] data; } acc_t; // 0 read, 1 colour, 2 depth
   acc_t        exp_q[$];
   int          n_cmp = 0, n_bad = 0, exp_in = 0, exp_drawn = 0, wait_cfg = 0, hold_left = 0, cyc;
   logic [31:0] stored_depth = 32'h0, last_color = 32'h0;
   bit          pend = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] model_w3(input logic [31:0] w1, input logic [31:0] w2);
      return 32'h0001_0000 - w1 - w2;
   endfunction

   // Exact weighted sum in 64-bit integers; >>> 16 on a longint is floor division by 65536.
   function automatic logic [7:0] model_ch(input logic [31:0] w1, input logic [31:0] w2,
                                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      longint s, q;
      s = longint'($signed(w1)) * longint'(a) + longint'($signed(w2)) * longint'(b)
        + longint'($signed(model_w3(w1, w2))) * longint'(c);
      q = s >>> 16;
      if (q < 0)   return 8'h00;
      if (q > 255) return 8'hFF;
      return q[7:0];
   endfunction

   function automatic logic [23:0] model_rgb(input logic [31:0] w1, input logic [31:0] w2,
                                             input logic [23:0] c1, input logic [23:0] c2, input logic [23:0] c3);
      return {model_ch(w1, w2, c1[23:16], c2[23:16], c3[23:16]),
              model_ch(w1, w2, c1[15:8],  c2[15:8],  c3[15:8]),
              model_ch(w1, w2, c1[7:0],   c2[7:0],   c3[7:0])};
   endfunction

   // Avalon slave: programmable waitrequest per access, read data one cycle after acceptance.
   initial begin
      bus.mem_waitrequest = 1'b0; bus.mem_readdatavalid = 1'b0; bus.mem_readdata = 32'h0;
      forever begin
         @(posedge clock); #1;
         bus.mem_readdatavalid = pend;
         bus.mem_readdata      = pend ? stored_depth : 32'h0;
         pend = 1'b0;
         if ((bus.mem_read || bus.mem_write) && hold_left > 0) begin
            bus.mem_waitrequest = 1'b1; hold_left--;
         end else begin
            bus.mem_waitrequest = 1'b0;
         end
         @(negedge clock);
         if (bus.mem_read && !bus.mem_waitrequest) pend = 1'b1;
         if ((bus.mem_read || bus.mem_write) && !bus.mem_waitrequest) hold_left = wait_cfg;
      end
   end

   // Compare process: every accepted access against the scoreboard, every held cycle for stability.
   initial begin
      acc_t e; bit prev_hold; logic [AW-1:0] p_addr; logic [31:0] p_data; logic [1:0] p_rw;
      prev_hold = 1'b0; p_addr = '0; p_data = 32'h0; p_rw = 2'b00;
      forever begin
         @(negedge clock);
         if (reset) begin
            if (prev_hold) begin
               check("hold_rw", {bus.mem_read, bus.mem_write}, p_rw);
               check("hold_addr", bus.mem_addr, p_addr);
               check("hold_data", bus.mem_writedata, p_data);
            end
            if (bus.mem_read || bus.mem_write) begin
               check("rd_wr_exclusive", bus.mem_read && bus.mem_write, 1'b0);
               check("stall_during_access", bus.stall_out, 1'b1);
               if (!bus.mem_waitrequest) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_access", bus.mem_addr, {AW{1'b1}});
                  end else begin
                     e = exp_q.pop_front();
                     check("access_kind", bus.mem_write, (e.kind != 0));
                     check("access_addr", bus.mem_addr, e.addr);
                     if (e.kind != 0) check("access_wdata", bus.mem_writedata, e.data);
                     if (e.kind == 1) last_color = bus.mem_writedata;
                  end
               end
            end
         end
         prev_hold = reset && (bus.mem_read || bus.mem_write) && bus.mem_waitrequest;
         p_rw = {bus.mem_read, bus.mem_write}; p_addr = bus.mem_addr; p_data = bus.mem_writedata;
      end
   end

   // Present a fragment, wait (bounded) for acceptance, then record the accesses it must produce.
   task automatic frag(input logic [AW-1:0] a, input logic [23:0] c1, input logic [23:0] c2,
                       input logic [23:0] c3, input logic [31:0] w1, input logic [31:0] w2,
                       input logic [31:0] d, input logic [31:0] st);
      acc_t e; bit ok;
      bus.addr_in = a; bus.color_in_1 = c1; bus.color_in_2 = c2; bus.color_in_3 = c3;
      bus.w1_in = w1; bus.w2_in = w2; bus.depth_in = d; stored_depth = st;
      bus.in_valid = 1'b1; ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (!bus.stall_out) begin ok = 1'b1; break; end
         check("held_while_busy", frag_in_count, exp_in);
      end
      if (!ok) check("accept_timeout", 1'b0, 1'b1);
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      exp_in++;
      e.kind = 0; e.addr = a + 26'd4; e.data = 32'h0; exp_q.push_back(e);
      if ($signed(d) < $signed(st)) begin
         e.kind = 1; e.addr = a; e.data = {8'h00, model_rgb(w1, w2, c1, c2, c3)}; exp_q.push_back(e);
         e.kind = 2; e.addr = a + 26'd4; e.data = d; exp_q.push_back(e);
         exp_drawn++;
      end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         n++;
         if (!bus.stall_out) break;
      end
      check("idle_reached", bus.stall_out, 1'b0);
      check("all_accesses_seen", exp_q.size(), 0);
      check("in_count", frag_in_count, exp_in);
      check("drawn_count", frag_drawn_count, exp_drawn);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.addr_in = '0; bus.color_in_1 = 24'h0; bus.color_in_2 = 24'h0; bus.color_in_3 = 24'h0;
      bus.w1_in = 32'h0; bus.w2_in = 32'h0; bus.depth_in = 32'h0; bus.in_valid = 1'b0; done_in = 1'b0;

      check("pin_w3", model_w3(32'h5555, 32'h5555), 32'h5556);
      check("pin_rgb_unit", model_rgb(32'h10000, 32'h0, 24'hFF0000, 24'h00FF00, 24'h0000FF), 24'hFF0000);
      check("pin_rgb_third", model_rgb(32'h5555, 32'h5555, 24'hFF0000, 24'h00FF00, 24'h0000FF), 24'h545455);
      check("pin_clamp_hi", model_rgb(32'h18000, 32'h0, 24'hFF0000, 24'h000000, 24'h0000FF), 24'hFF0000);
      check("pin_clamp_lo", model_rgb(32'hFFFF8000, 32'h0, 24'hFF00FF, 24'h000000, 24'h00FF00), 24'h00FF00);

      repeat (2) @(posedge clock);
      #1;
      check("rst_stall", bus.stall_out, 1'b0);
      check("rst_read", bus.mem_read, 1'b0);
      check("rst_write", bus.mem_write, 1'b0);
      check("rst_addr", bus.mem_addr, 26'h0);
      check("rst_wdata", bus.mem_writedata, 32'h0);
      check("rst_done", done_out, 1'b0);
      check("rst_counts", {frag_in_count, frag_drawn_count}, 64'h0);
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1;

      // Depth test fails: only the read, three cycles busy.
      frag(26'h200, 24'hFF0000, 24'h00FF00, 24'h0000FF, 32'h10000, 32'h0, 32'h8000, 32'h4000);
      wait_idle(cyc);
      check("latency_fail", cyc, 3);
      check("fail_in_count", frag_in_count, 32'd1);
      check("fail_drawn_count", frag_drawn_count, 32'd0);

      frag(26'h100, 24'hFF0000, 24'h00FF00, 24'h0000FF, 32'h10000, 32'h0, 32'h8000, 32'h10000);
      wait_idle(cyc);
      check("latency_pass", cyc, 5);
      check("unit_color", last_color, 32'h00FF0000);
      check("pass_drawn_count", frag_drawn_count, 32'd1);

      frag(26'h108, 24'hFF0000, 24'h00FF00, 24'h0000FF, 32'h5555, 32'h5555, 32'h8000, 32'h10000);
      wait_idle(cyc);
      check("third_color", last_color, 32'h00545455);

      frag(26'h110, 24'hFF0000, 24'h000000, 24'h0000FF, 32'h18000, 32'h0, 32'h8000, 32'h10000);
      wait_idle(cyc);
      check("clamp_hi_color", last_color, 32'h00FF0000);
      frag(26'h118, 24'hFF00FF, 24'h000000, 24'h00FF00, 32'hFFFF8000, 32'h0, 32'hFFFF0000, 32'h0);
      wait_idle(cyc);
      check("clamp_lo_color", last_color, 32'h0000FF00);

      // Three wait cycles per access; second fragment presented while the first is in flight.
      wait_cfg = 3; hold_left = 3;
      frag(26'h120, 24'h102030, 24'h405060, 24'h708090, 32'h4000, 32'h8000, 32'h100, 32'h200);
      frag(26'h128, 24'hA0B0C0, 24'h010203, 24'hFFFFFF, 32'h2000, 32'hC000, 32'h100, 32'h200);
      wait_idle(cyc);
      wait_cfg = 0; hold_left = 0;

      done_in = 1'b1;
      @(posedge clock); #1;
      check("done_idle", done_out, 1'b1);
      done_in = 1'b0;
      @(posedge clock); #1;
      check("done_drops", done_out, 1'b0);
      done_in = 1'b1;
      frag(26'h130, 24'h00FF00, 24'h0000FF, 24'hFF0000, 32'h0, 32'h10000, 32'h10, 32'h20);
      check("done_withheld", done_out, 1'b0);
      wait_idle(cyc);
      @(posedge clock); #1;
      check("done_after_retire", done_out, 1'b1);
      done_in = 1'b0;

      // Reset while a colour write is held by waitrequest.
      wait_cfg = 10; hold_left = 10;
      frag(26'h138, 24'hFF0000, 24'h00FF00, 24'h0000FF, 32'h10000, 32'h0, 32'h8000, 32'h10000);
      for (int i = 0; i < 60 && !bus.mem_write; i++) begin
         @(posedge clock); #1;
      end
      check("reached_write", bus.mem_write, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("rst_kills_write", bus.mem_write, 1'b0);
      exp_q.delete(); wait_cfg = 0; hold_left = 0; exp_in = 0; exp_drawn = 0;
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1;
      check("post_rst_counts", {frag_in_count, frag_drawn_count}, 64'h0);
      check("post_rst_stall", bus.stall_out, 1'b0);
      check("post_rst_write", bus.mem_write, 1'b0);
      frag(26'h140, 24'h123456, 24'h654321, 24'hABCDEF, 32'h3000, 32'h7000, 32'h5, 32'h6);
      wait_idle(cyc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fragment_shader.md
Name: fragment_shader

Overview:
- Stage directly downstream of the triangle rasterizer.
- Accepts one fragment per handshake. Each fragment carries:
  - pixel address (framebuffer base + pixel_index*8)
  - three vertex colours
  - barycentric weights w1, w2 in Q16.16
  - interpolated depth
- Computes w3, interpolates the RGB colour and runs a depth test against the stored depth.
- Writes colour and depth to the framebuffer over a single Avalon-MM master port.
- Drives stall back to the rasterizer while a fragment is in flight.

Parameters:
- DEPTH_TEST_EN, 1: 0 means every fragment passes and no depth read is issued.
- DEPTH_WRITE_EN, 1: 0 means the depth word is never written (colour only).
- ADDR_W, 26: byte address width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- addr_in  in  ADDR_W  pixel byte address; colour word at addr_in, depth word at addr_in+4
- color_in_1/2/3  in  24  vertex RGB, [23:16]=R, [15:8]=G, [7:0]=B
- w1_in, w2_in  in  32  signed Q16.16 barycentric weights
- depth_in  in  32  signed Q16.16 fragment depth
- in_valid  in  1  fragment present
- done_in  in  1  rasterizer finished all triangles
- stall_out  out  1  1 = busy, upstream must hold or pause
- mem_addr  out  ADDR_W  byte address
- mem_read  out  1  read request
- mem_write  out  1  write request
- mem_writedata  out  32  write data
- mem_readdata  in  32  read data
- mem_readdatavalid  in  1  read data valid
- mem_waitrequest  in  1  slave not ready; hold request
- done_out  out  1  all fragments retired and upstream done
- frag_in_count  out  32  fragments accepted
- frag_drawn_count  out  32  fragments that passed and were written

Behaviour:
- Reset (async, active-low):
  - state=S_IDLE; stall_out=0; mem_read=0; mem_write=0; mem_addr=0; mem_writedata=0.
  - done_out=0; both counters=0.
  - An in-flight access is abandoned; no partial write completes after reset.
- Accept rule:
  - A fragment is accepted on a rising edge where in_valid=1 and stall_out=0.
  - All inputs are latched on that edge and frag_in_count increments.
  - stall_out=1 in every state except S_IDLE.
- States:
  - S_IDLE: on accept go to S_SHADE.
  - S_SHADE:
    - Register the shaded colour.
    - Go to S_RD_DEPTH, or S_WR_COLOR if DEPTH_TEST_EN=0.
  - S_RD_DEPTH: mem_read=1, mem_addr=addr+4. Hold while mem_waitrequest=1, then go to S_WAIT_DEPTH.
  - S_WAIT_DEPTH: on mem_readdatavalid, compare signed depth_latched < mem_readdata.
    - True: go to S_WR_COLOR.
    - False: fragment is discarded; go to S_IDLE.
  - S_WR_COLOR:
    - mem_write=1, mem_addr=addr, mem_writedata={8'h00, rgb}.
    - Hold until !mem_waitrequest.
    - Then go to S_WR_DEPTH, or to S_IDLE if DEPTH_WRITE_EN=0 (frag_drawn_count++ on leaving).
  - S_WR_DEPTH:
    - mem_write=1, mem_addr=addr+4, mem_writedata=depth.
    - Hold until !mem_waitrequest, then go to S_IDLE.
    - frag_drawn_count++ on leaving.
- Avalon requests: address, data and request stay stable while mem_waitrequest=1. Read and write are never asserted together.
- Arithmetic:
  - w3 = 32'h0001_0000 - w1 - w2, modulo 2^32.
  - Per channel: sum = w1*c1 + w2*c2 + w3*c3.
    - Each ci is zero-extended to 9 bits signed; products and sum are 42-bit signed.
  - ch = sum >>> 16, clamped to [0,255]. Negative values go to 0, values >255 go to 255.
- Latency with zero waitrequest and read data arriving 1 cycle after the read is accepted:
  - Passing fragment: 5 cycles from accept to return to S_IDLE.
  - Failing fragment: 3 cycles.
- done_out: registered; equals done_in && state==S_IDLE && !in_valid. It drops when done_in drops.
- Simultaneous done_in and in_valid: the fragment is accepted first; done_out is withheld until it retires.
- Counters wrap at 2^32.

Decomposition:
- Package raster_pkg holds:
  - FP_ONE=32'h10000, FP_FRAC=16
  - SCREEN_W=640, PIXEL_BYTES=8, DEPTH_OFS=4
  - typedef enum fs_state_t {S_IDLE, S_SHADE, S_RD_DEPTH, S_WAIT_DEPTH, S_WR_COLOR, S_WR_DEPTH}
- Sub-module color_interp: combinational. Inputs w1, w2, w3 and three 8-bit channels; output one clamped 8-bit channel. Instantiated three times (R, G, B).

Test Plan:
- w1=0x10000, w2=0, colours FF0000/00FF00/0000FF, depth 0x8000, stored depth 0x10000, addr 0x100 -> read at 0x104; writes 0x00FF0000@0x100 then 0x8000@0x104; frag_drawn_count=1.
- w1=w2=0x5555, same colours -> written colour 0x555555 ±1 LSB per channel; w3 computed as 0x5556.
- Stored depth 0x4000, fragment depth 0x8000 -> no write issued; S_IDLE after read data; frag_in_count=1, frag_drawn_count=0.
- mem_waitrequest high for 3 cycles on each access -> mem_addr and mem_writedata stable throughout; stall_out=1 throughout; the next in_valid fragment is not accepted until S_IDLE.
- w1=0x18000, w2=0, c1=FF -> channel clamps to 0xFF; w1=-0x8000, w2=0, c1=FF, c3=0 -> channel clamps to 0x00.
- Reset asserted during S_WR_COLOR -> mem_write=0 immediately; counters=0 and stall_out=0 after release. Separately: done_in=1 with in_valid=0 in S_IDLE -> done_out=1 on the next edge.
